// File: rtl/mips_pkg.sv
// Shared constants and fetch-state encoding for the mips fetch front end.
//   ADDR_W : word-address width of instruction memory and of the PC
//   WORD_W : instruction word width
//   DEPTH  : default fetch-buffer depth
package mips_pkg;

  localparam int ADDR_W = 5;
  localparam int WORD_W = 32;
  localparam int DEPTH  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no request outstanding
    REQ  = 2'd1,  // request outstanding, data will be kept
    DROP = 2'd2   // request outstanding, data will be discarded
  } fetch_state_e;

endpackage

// File: rtl/mips_fetch_fifo.sv
// Small synchronous FIFO holding {pc, word} fetch entries.
//   clk, reset      : clock, async active-high reset
//   push, push_data : write an entry (ignored while flush=1)
//   pop             : remove head (ignored when empty or flush=1)
//   flush           : discard all entries; outranks push and pop
//   head_valid      : FIFO non-empty
//   head_data       : head entry; holds the last shown value while empty
//   count           : number of stored entries (0..DEPTH)
module mips_fetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 37,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic          head_valid,
  output logic [W-1:0]  head_data,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [W-1:0]  hold_q;
  logic          do_push, do_pop;

  assign head_valid = (count != '0);
  assign do_push    = push && !flush;
  assign do_pop     = pop && head_valid && !flush;

  // While empty the output shows the last value it presented rather than
  // a stale storage slot, so the consumer side never sees it change.
  assign head_data  = head_valid ? mem[rd_ptr] : hold_q;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      hold_q <= '0;
    end else begin
      hold_q <= head_data;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(do_push) - CW'(do_pop);
      end
    end
  end

endmodule

// File: rtl/mips_ifetch.sv
// Instruction-fetch stage: owns the fetch PC, reads instruction memory over
// a req/ack handshake, buffers {pc, word} and presents it on valid/ready.
//   clk, reset          : clock, async active-high reset
//   enable              : allow new fetch requests
//   redirect/_pc        : 1-cycle pulse, flush and restart fetch at redirect_pc
//   imem_req/addr       : registered read request, held until imem_ack
//   imem_ack/rdata      : read completion and data
//   instr_valid/instr/instr_pc : buffer head towards the core
//   instr_ready         : consumer accepts head
module mips_ifetch
  import mips_pkg::*;
#(
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int WORD_W = mips_pkg::WORD_W,
  parameter int DEPTH  = mips_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic              instr_valid,
  output logic [WORD_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = ADDR_W + WORD_W;

  fetch_state_e      state, state_n;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_n, addr_n;
  logic              req_n;
  logic              push, pop;
  logic [CW-1:0]     count;
  logic [CW:0]       cnt_after;
  logic              has_space, room_after;
  logic [EW-1:0]     head;

  mips_fetch_fifo #(.DEPTH(DEPTH), .W(EW), .CW(CW)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  ({fetch_pc, imem_rdata}),
    .pop        (pop),
    .flush      (redirect),
    .head_valid (instr_valid),
    .head_data  (head),
    .count      (count)
  );

  assign instr_pc = head[EW-1:WORD_W];
  assign instr    = head[WORD_W-1:0];

  // Redirect flushes the buffer, so a pop on the same edge is suppressed.
  assign pop = instr_valid && instr_ready && !redirect;

  always_comb begin
    state_n    = state;
    req_n      = imem_req;
    addr_n     = imem_addr;
    fetch_pc_n = fetch_pc;
    push       = 1'b0;
    // Occupancy after a push at this edge; decides back-to-back issue.
    cnt_after  = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);
    has_space  = (count < CW'(DEPTH));
    room_after = (cnt_after < (CW+1)'(DEPTH));

    case (state)
      IDLE: begin
        if (redirect) begin
          fetch_pc_n = redirect_pc;
        end else if (enable && has_space) begin
          state_n = REQ;
          req_n   = 1'b1;
          addr_n  = fetch_pc;
        end
      end
      REQ: begin
        if (redirect) begin
          fetch_pc_n = redirect_pc;
          if (imem_ack) begin
            state_n = IDLE;
            req_n   = 1'b0;
          end else begin
            // Request cannot be withdrawn; wait for its ack and discard it.
            state_n = DROP;
          end
        end else if (imem_ack) begin
          push       = 1'b1;
          fetch_pc_n = fetch_pc + ADDR_W'(1);
          if (enable && room_after) begin
            addr_n = fetch_pc + ADDR_W'(1);
          end else begin
            state_n = IDLE;
            req_n   = 1'b0;
          end
        end
      end
      DROP: begin
        if (redirect) fetch_pc_n = redirect_pc;
        if (imem_ack) begin
          state_n = IDLE;
          req_n   = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        req_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      fetch_pc  <= '0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      state     <= state_n;
      fetch_pc  <= fetch_pc_n;
      imem_req  <= req_n;
      imem_addr <= addr_n;
    end
  end

endmodule
